// File: rtl/lsu_ram_port.sv
// Load/store sequencer for a word-organised single-port RAM on a shared data bus.
// Sub-word stores are read-modify-write; misaligned or illegal requests return an error without touching the RAM.
module lsu_ram_port #(
    parameter int RAM_WIDTH  = 31,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [RAM_WIDTH-1:0]  ram_address,
    output logic                  we,
    inout  wire  [DATA_WIDTH-1:0] data
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

    state_t               state, state_next;
    logic                 st_uns;
    logic [1:0]           st_size;
    logic [1:0]           st_off;
    logic [31:0]          merge;
    logic                 misaligned;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [31:0]          load_ext;
    logic [31:0]          merged;
    logic [RAM_WIDTH-1:0] word_addr;

    generate
        if (RAM_WIDTH >= ADDR_WIDTH - 2) begin : g_zext
            assign word_addr = RAM_WIDTH'(req_addr[ADDR_WIDTH-1:2]);
        end else begin : g_trunc
            assign word_addr = req_addr[RAM_WIDTH+1:2];
        end
    endgenerate

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign we        = (state == WR);
    // The RAM owns the bus whenever we is low.
    assign data      = we ? merge : 'z;

    always_comb begin
        misaligned = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned)             state_next = RESP;
                    else if (!req_we)           state_next = RD;
                    else if (req_size == 2'b10) state_next = WR;
                    else                        state_next = RMW_RD;
                end
            end
            RD:      state_next = RESP;
            RMW_RD:  state_next = WR;
            WR:      state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        byte_sel = data[{st_off, 3'b000} +: 8];
        half_sel = st_off[1] ? data[31:16] : data[15:0];
        load_ext = data;
        case (st_size)
            2'b00:   load_ext = st_uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = st_uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_ext = data;
        endcase
        // merge still holds the right-aligned store data while in RMW_RD
        merged = data;
        case (st_size)
            2'b00: merged[{st_off, 3'b000} +: 8] = merge[7:0];
            2'b01: begin
                if (st_off[1]) merged[31:16] = merge[15:0];
                else           merged[15:0]  = merge[15:0];
            end
            default: merged = data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            st_uns      <= 1'b0;
            st_size     <= 2'b00;
            st_off      <= 2'b00;
            merge       <= '0;
            ram_address <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        st_uns      <= req_unsigned;
                        st_size     <= req_size;
                        st_off      <= req_addr[1:0];
                        merge       <= req_wdata;
                        ram_address <= word_addr;
                        rsp_rdata   <= '0;
                        rsp_err     <= misaligned;
                    end
                end
                RD:      rsp_rdata <= load_ext;
                RMW_RD:  merge     <= merged;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ram_port.sv
// Bench for lsu_ram_port: word RAM model on the shared bus, constant test vectors,
// hand sequences for back-pressure and reset, and random traffic against a byte-level reference.
module tb_lsu_ram_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_unsigned, rsp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err, we;
    logic [31:0] rsp_rdata;
    logic [30:0] ram_address;
    wire  [31:0] data;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:255];
    logic [7:0]  rmem [0:1023];

    always #5 clk = ~clk;

    assign data = we ? 32'bz : mem[ram_address[7:0]];
    always @(posedge clk) if (we) mem[ram_address[7:0]] <= data;

    lsu_ram_port dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ram_address(ram_address),
        .we(we), .data(data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]};
    endfunction

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
        longint v = 0;
        int n = 1 << sz;
        for (int i = 0; i < n; i++) v = v + (longint'(rmem[a + i]) << (8 * i));
        if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n = 1 << sz;
        for (int i = 0; i < n; i++) rmem[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic e, output int lat,
                          output int wes, output logic [30:0] wa, output logic [31:0] wdat);
        int k = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL req_timeout actual=busy required=ready");
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; wes = 0; wa = '0; wdat = '0;
        while (!rsp_valid && lat < 20) begin
            if (we) begin wes++; wa = ram_address; wdat = data; end
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            checks++; failures++;
            $display("FAIL rsp_timeout actual=no_rsp required=rsp_valid");
        end
        if (we) wes++;
        rd = rsp_rdata;
        e = rsp_err;
        @(posedge clk);
    endtask

    task automatic run(input string nm, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic ee, input int elat);
        logic [31:0] rd, wdat;
        logic        e;
        int          lat, wes;
        logic [30:0] wa;
        do_req(w, sz, u, a, wd, rd, e, lat, wes, wa, wdat);
        chk({nm, ".rdata"}, rd, erd);
        chk({nm, ".err"}, 32'(e), 32'(ee));
        chk({nm, ".latency"}, 32'(lat), 32'(elat));
        chk({nm, ".we_cycles"}, 32'(wes), (w && !ee) ? 32'd1 : 32'd0);
        if (w && !ee) begin
            ref_store(sz, a, wd);
            chk({nm, ".wr_addr"}, {1'b0, wa}, a >> 2);
            chk({nm, ".wr_data"}, wdat, ref_word(int'(a >> 2)));
        end
    endtask

    task automatic reset_vals(input string nm);
        chk({nm, ".req_ready"}, 32'(req_ready), 32'd1);
        chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, ".rsp_rdata"}, rsp_rdata, 32'd0);
        chk({nm, ".rsp_err"}, 32'(rsp_err), 32'd0);
        chk({nm, ".we"}, 32'(we), 32'd0);
        chk({nm, ".ram_address"}, {1'b0, ram_address}, 32'd0);
        chk({nm, ".bus_released"}, data, mem[0]);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        e;
        int          lat;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [31:0] held;
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 2};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h000000DE, 1'b0, 2};
        tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 2};
        tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, 2};
        tbl[6]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAAAA55, 32'h0,        1'b0, 3};
        tbl[7]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'hBBBB1234, 32'h0,        1'b0, 3};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h123455EF, 1'b0, 2};
        tbl[9]  = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 1};
        tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h12, 32'hCAFEF00D, 32'h0,        1'b1, 1};
        tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1};
        tbl[12] = '{1'b0, 2'd2, 1'b1, 32'h10, 32'h0,        32'h123455EF, 1'b0, 2};

        for (int w = 0; w < 256; w++) begin
            mem[w] = $urandom;
            for (int b = 0; b < 4; b++) rmem[4*w+b] = 8'((mem[w] >> (8 * b)) & 32'hFF);
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_vals("reset");

        for (int i = 0; i < 13; i++)
            run($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd,
                tbl[i].rd, tbl[i].e, tbl[i].lat);

        // back-pressure: word load stalled in RESP while the next request waits
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2;
        req_unsigned = 1'b0; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_size = 2'd0; req_unsigned = 1'b1; req_addr = 32'h13;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp.rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp.rdata", rsp_rdata, 32'h123455EF);
            chk("bp.err", 32'(rsp_err), 32'd0);
            chk("bp.req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp.ready_after", 32'(req_ready), 32'd1);
        chk("bp.valid_after", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp.next_rd_cycle", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("bp.next_valid", 32'(rsp_valid), 32'd1);
        chk("bp.next_rdata", rsp_rdata, 32'h00000012);
        @(posedge clk);

        // reset during RMW_RD: the sub-word store must not land
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h21; req_wdata = 32'hA5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_rmw.in_rmw_we", 32'(we), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_vals("rst_rmw");
        repeat (2) @(negedge clk);
        chk("rst_rmw.word_kept", mem[8], ref_word(8));

        // reset during RESP: the pending response is dropped
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_resp.valid_before", 32'(rsp_valid), 32'd1);
        chk("rst_resp.rdata_before", rsp_rdata, 32'h123455EF);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        reset_vals("rst_resp");

        for (int i = 0; i < 300; i++) begin
            logic        w, u, ee;
            logic [1:0]  sz;
            logic [31:0] a, wd, erd;
            int          elat;
            w = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 255));
            wd = $urandom;
            ee = ref_err(sz, a);
            erd = (w || ee) ? 32'h0 : ref_load(sz, u, a);
            elat = ee ? 1 : (!w || sz == 2'd2) ? 2 : 3;
            run($sformatf("rnd%0d", i), w, sz, u, a, wd, erd, ee, elat);
        end

        @(negedge clk);
        for (int w = 0; w < 64; w++) chk($sformatf("ram_word%0d", w), mem[w], ref_word(w));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_ram_port.md
# lsu_ram_port

Load/store initiator for the word-organised single-port RAM. It accepts byte/half/word load and store requests from the core over a valid/ready handshake and sequences them onto the RAM's address / write-enable / shared bidirectional data bus. Loads are sign- or zero-extended, and sub-word stores run as read-modify-write. Responses, including a misalignment error, return on a valid/ready channel. It sits between the core's memory stage and the RAM; it is the only driver of the RAM's address and write-enable.

## Interface
- RAM_WIDTH, 31, RAM word-address width; must match the attached RAM.
- DATA_WIDTH, 32, RAM word width; only 32 is supported (four byte lanes).
- ADDR_WIDTH, 32, request byte-address width.

- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned or illegal-size request, no RAM access made.
- ram_address  output  RAM_WIDTH  word address = req_addr >> 2, truncated or zero-extended to RAM_WIDTH.
- we  output  1  RAM write enable.
- data  inout  32  shared RAM data bus.

## Operation
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE: req_ready=1. A handshake (req_valid & req_ready) latches we, size, unsigned, addr[1:0], word address and wdata.
- Next state after a handshake:
  - misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size=11 → RESP with err=1;
  - load → RD;
  - word store → WR;
  - byte/half store → RMW_RD.
- RD: we=0, data released. At the edge, capture the selected lane (byte lane addr[1:0]; half lane addr[1]), extend it per unsigned into rdata, then → RESP.
- RMW_RD: we=0, data released. At the edge, capture the RAM word into the merge register with the target lane replaced by wdata[7:0] or wdata[15:0], then → WR.
- WR: we=1, data driven with the merge register (word store: wdata). → RESP.
- RESP: rsp_valid=1, req_ready=0, rsp_rdata and rsp_err stable. Leave to IDLE on rsp_ready. A new request is accepted only in IDLE, one cycle after the response handshake.
- data is driven by this block only when we=1; it is high-Z in every other state and during reset.
- ram_address always presents the latched word address and holds it between requests.

## Timing
- Reset state: IDLE, req_ready=1 after the reset cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0, we=0, ram_address=0, data high-Z.
- we, the data drive and req_ready/rsp_valid decode combinationally from the state register. rsp_rdata and rsp_err are registered.
- RAM read is combinational and RAM write commits at the posedge where we=1.
- Latency from handshake cycle N to the first rsp_valid cycle:
  - load: RD in N+1, RESP in N+2;
  - word store: WR in N+1, RESP in N+2;
  - sub-word store: RMW_RD in N+1, WR in N+2, RESP in N+3;
  - error: RESP in N+1.
- The RAM write is visible to a load issued after the store's response.
- Back-pressure: RESP holds indefinitely with outputs unchanged while rsp_ready=0.
- Reset mid-operation: rst sampled high in any state goes to IDLE at that edge. A WR cycle coinciding with rst still has we=1, so that write commits. A pending response is dropped.
- req_valid while not in IDLE is ignored (req_ready=0). The core holds the request stable until accepted.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load from 0x10: we=1 for exactly one cycle with ram_address=4, data=0xDEADBEEF. The load returns rsp_rdata=0xDEADBEEF, err=0, 2 cycles after each handshake.
- With word 4 = 0xDEADBEEF:
  - signed byte load from 0x13 → 0xFFFFFFDE;
  - unsigned byte load from 0x13 → 0x000000DE;
  - signed half load from 0x10 → 0xFFFFBEEF;
  - unsigned half load from 0x12 → 0x0000DEAD.
- Byte store 0x55 to 0x11, then half store 0x1234 to 0x12: each shows RMW_RD then WR, with response at N+3. The word reads 0x123455EF.
- Misaligned half load at 0x11, word store at 0x12, and size=11: rsp_err=1, rsp_rdata=0, response at N+1, we never asserted, RAM contents unchanged.
- Hold rsp_ready=0 for 5 cycles with req_valid held high: rsp_valid, rsp_rdata and rsp_err stay stable and req_ready=0. The request is accepted one cycle after the response handshake.
- Assert rst during RMW_RD and during RESP: the next cycle is IDLE with all outputs at reset values and data high-Z. The interrupted sub-word store leaves the RAM word unchanged.
